keypad_event_fifo: RTL and testbench

Debounces the scanner's decoded key output and turns each new key press into a 4-bit event queued in a small FIFO. The CPU (via the peripheral bus decoder) or a display stage pops events one at a time. Sits directly downstream of `keypad` (scan/decode) and upstream of the MMIO read mux or `seven_segs`. It replaces the direct, unbuffered `key_val` → display connection, so keys pressed while the consumer is busy are no longer lost.

---
 rtl/keypad_event_fifo.sv | 160 ++++++++++++++++
 tb/tb_keypad_event_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo
// Debounces the keypad scanner's decoded output. Each newly accepted key press
// becomes a 4-bit event in a small first-word-fall-through FIFO. Events are
// popped one at a time by the CPU or the display stage.
//
// Build option: define KEYPAD_IRQ_EN to add a registered `irq` output. It is
// set while events are queued or the overflow flag is set.
module keypad_event_fifo #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_valid,
    input  logic [3:0]                    key_val,
    input  logic                          rd_en,
    input  logic                          clr_ovf,
    output logic [3:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
`ifdef KEYPAD_IRQ_EN
    ,
    output logic                          irq
`endif
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int DCW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCW-1:0] DB_TC   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    // Debouncer registers hold {valid, code}
    logic [4:0]     sample_q, sample_d;
    logic [4:0]     cand_q, cand_d;
    logic [4:0]     stable_q, stable_d;
    logic [DCW-1:0] db_cnt_q, db_cnt_d;
    logic           press;

    logic [3:0]     mem_q [FIFO_DEPTH];
    logic [3:0]     mem_d [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           pop, push, drop;

    // Debounce: a value must survive a full terminal count before it becomes
    // stable; a press event is the cycle a valid key becomes stable.
    always_comb begin
        sample_d = {key_valid, key_valid ? key_val : 4'h0};
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        press    = 1'b0;
        if (sample_q != cand_q) begin
            cand_d   = sample_q;
            db_cnt_d = '0;
        end else if (db_cnt_q < DB_TC) begin
            db_cnt_d = db_cnt_q + DCW'(1);
        end else if (cand_q != stable_q) begin
            stable_d = cand_q;
            press    = cand_q[4];
        end
    end

    // FIFO next state: a pop frees a slot in the same cycle, so push-while-full
    // with a pop is accepted rather than dropped.
    always_comb begin
        pop        = rd_en && (count_q != '0);
        drop       = press && (count_q == DEPTH_C) && !pop;
        push       = press && !drop;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = stable_d[3:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // A drop in the same cycle as a clear leaves the flag set
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q   <= '0;
            cand_q     <= '0;
            stable_q   <= '0;
            db_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
        end else begin
            sample_q   <= sample_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

`ifdef KEYPAD_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt raised by a push into an empty FIFO or by a drop; it holds
    // until the queue has drained and overflow has been cleared.
    always_comb begin
        irq_d = irq_q;
        if ((push && (count_q == '0)) || drop) begin
            irq_d = 1'b1;
        end else if ((count_d == '0) && !overflow_d) begin
            irq_d = 1'b0;
        end
    end

    // Interrupt register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign rd_data  = (count_q == '0) ? 4'h0 : mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Testbench for keypad_event_fifo (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// The reference model treats debouncing as "a value applied for
// DEBOUNCE_CYCLES+1 consecutive edges is accepted on the next edge".
// The FIFO is modelled as a plain queue.
module tb_keypad_event_fifo;

    localparam int DB    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_val;
    logic       rd_en;
    logic       clr_ovf;
    logic [3:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;
`ifdef KEYPAD_IRQ_EN
    logic       irq;
`endif

    keypad_event_fifo #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_val   (key_val),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
`ifdef KEYPAD_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [4:0] last_in_m;
    int         run_len_m;
    logic [4:0] stable_m;
    logic [3:0] q_m [$];
    logic       ovf_m;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_in_m = 5'h0;
        run_len_m = 0;
        stable_m  = 5'h0;
        q_m.delete();
        ovf_m     = 1'b0;
    endtask

    task automatic model_edge();
        logic [4:0] cur;
        logic       press_m;
        logic       pop_m;
        logic       drop_m;
        int         sz;
        cur     = {key_valid, key_valid ? key_val : 4'h0};
        press_m = 1'b0;
        if (run_len_m >= DB + 1 && last_in_m != stable_m) begin
            stable_m = last_in_m;
            press_m  = last_in_m[4];
        end
        if (cur == last_in_m) begin
            if (run_len_m < 1000) run_len_m++;
        end else begin
            last_in_m = cur;
            run_len_m = 1;
        end
        sz     = q_m.size();
        pop_m  = rd_en && (sz > 0);
        drop_m = press_m && (sz == DEPTH) && !pop_m;
        if (pop_m) void'(q_m.pop_front());
        if (press_m && !drop_m) q_m.push_back(stable_m[3:0]);
        if (drop_m) ovf_m = 1'b1;
        else if (clr_ovf) ovf_m = 1'b0;
    endtask

    task automatic compare_all();
        int sz;
        sz = q_m.size();
        check("rd_data",  {4'h0, rd_data},  {4'h0, (sz > 0) ? q_m[0] : 4'h0});
        check("empty",    {7'h0, empty},    {7'h0, sz == 0});
        check("full",     {7'h0, full},     {7'h0, sz == DEPTH});
        check("count",    {5'h0, count},    8'(sz));
        check("overflow", {7'h0, overflow}, {7'h0, ovf_m});
`ifdef KEYPAD_IRQ_EN
        check("irq",      {7'h0, irq},      {7'h0, (sz != 0) || ovf_m});
`endif
    endtask

    task automatic step(input logic kv, input logic [3:0] kval, input logic rd, input logic clr);
        key_valid = kv;
        key_val   = kval;
        rd_en     = rd;
        clr_ovf   = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic press(input logic [3:0] code);
        for (int i = 0; i < 8; i++) step(1'b1, code, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int first_fall;
        logic [3:0] codes [5];
        rst_n = 1'b0; key_valid = 1'b0; key_val = 4'h0; rd_en = 1'b0; clr_ovf = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset while a key is held with an event queued
        for (int i = 0; i < 8; i++) step(1'b1, 4'h5, 1'b0, 1'b0);
        check("pre_reset_count", {5'h0, count}, 8'd1);
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_empty",   {7'h0, empty},    8'd1);
        check("rst_count",   {5'h0, count},    8'd0);
        check("rst_rd_data", {4'h0, rd_data},  8'd0);
        check("rst_ovf",     {7'h0, overflow}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        key_valid = 1'b0;
        rst_n     = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
        check("post_reset_empty", {7'h0, empty}, 8'd1);

        // Single press: empty must fall exactly 6 edges after the change
        first_fall = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 4'h7, 1'b0, 1'b0);
            if (!empty && first_fall == 0) first_fall = i;
        end
        check("single_latency", 8'(first_fall), 8'd6);
        check("single_data", {4'h0, rd_data}, 8'h7);
        check("single_count", {5'h0, count}, 8'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        check("single_pop_empty", {7'h0, empty}, 8'd1);
        check("single_pop_data", {4'h0, rd_data}, 8'h0);

        // Bounce rejection
        for (int i = 0; i < 30; i++) step(((i / 2) % 2) == 0, 4'h3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 4'h3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
        check("bounce_count", {5'h0, count}, 8'd1);
        check("bounce_data", {4'h0, rd_data}, 8'h3);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        // Roll-over without release
        for (int i = 0; i < 10; i++) step(1'b1, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 4'h2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
        check("roll_count", {5'h0, count}, 8'd2);
        check("roll_first", {4'h0, rd_data}, 8'h1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        check("roll_second", {4'h0, rd_data}, 8'h2);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        check("roll_drained", {7'h0, empty}, 8'd1);

        // Overflow: five presses into a four-entry FIFO
        codes[0] = 4'hA; codes[1] = 4'hB; codes[2] = 4'hC; codes[3] = 4'hD; codes[4] = 4'hE;
        for (int i = 0; i < 5; i++) press(codes[i]);
        check("ovf_full", {7'h0, full}, 8'd1);
        check("ovf_count", {5'h0, count}, 8'd4);
        check("ovf_flag", {7'h0, overflow}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_pop_data", {4'h0, rd_data}, {4'h0, codes[i]});
            step(1'b0, 4'h0, 1'b1, 1'b0);
        end
        step(1'b0, 4'h0, 1'b0, 1'b1);
        check("ovf_cleared", {7'h0, overflow}, 8'd0);

        // Push and pop in the same cycle while full
        press(4'h4); press(4'h5); press(4'h6); press(4'h8);
        for (int i = 0; i < 5; i++) step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b1, 1'b0);
        check("simul_count", {5'h0, count}, 8'd4);
        check("simul_ovf", {7'h0, overflow}, 8'd0);
        check("simul_head", {4'h0, rd_data}, 8'h5);
        for (int i = 0; i < 4; i++) step(1'b1, 4'h9, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        check("simul_last", {4'h0, rd_data}, 8'h9);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        // Randomized key activity, pops and overflow clears
        for (int s = 0; s < 300; s++) begin
            logic       kv;
            logic [3:0] kval;
            int         len;
            kv   = ($urandom_range(0, 3) != 0);
            kval = 4'($urandom_range(0, 15));
            len  = $urandom_range(1, 9);
            for (int i = 0; i < len; i++)
                step(kv, kval, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
